// File: rtl/evict_write_buffer_pkg.sv
// Shared types for the L2 eviction write buffer: drain FSM states and the
// default-sized entry record.
package evict_write_buffer_pkg;

  localparam int EWB_DEPTH  = 4;
  localparam int EWB_DATA_W = 128;
  localparam int EWB_ADDR_W = 12;

  typedef enum logic [1:0] {
    EWB_IDLE,
    EWB_WRITE,
    EWB_GAP
  } ewb_state_t;

  typedef struct packed {
    logic                  valid;
    logic [EWB_ADDR_W-1:0] addr;
    logic [EWB_DATA_W-1:0] data;
  } ewb_entry_t;

endpackage

// File: rtl/ewb_match.sv
// DEPTH-way address comparator; returns the youngest candidate entry (FIFO
// order counted from head) whose address equals key. Purely combinational.
module ewb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128
) (
  input  logic [DEPTH-1:0]         cand,
  input  logic [DEPTH*ADDR_W-1:0]  addrs,
  input  logic [DEPTH*DATA_W-1:0]  datas,
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [ADDR_W-1:0]        key,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic [DATA_W-1:0]        data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_a [DEPTH];
  logic [DATA_W-1:0] data_a [DEPTH];
  logic [PTR_W-1:0]  slot;

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    assign addr_a[g] = addrs[g*ADDR_W +: ADDR_W];
    assign data_a[g] = datas[g*DATA_W +: DATA_W];
  end

  // Walk from oldest to youngest so the last match seen wins.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PTR_W'(k);
      if (cand[slot] && (addr_a[slot] == key)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

  assign data = hit ? data_a[idx] : '0;

endmodule

// File: rtl/evict_write_buffer.sv
// Multi-entry eviction write buffer between L2 and memory: FIFO drain with a
// one-cycle gap between lines, coalescing of repeat evictions, read forwarding.
module evict_write_buffer
  import evict_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ewb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic [DEPTH*ADDR_W-1:0] addr_flat;
  logic [DEPTH*DATA_W-1:0] data_flat;
  logic [DEPTH-1:0]        head_mask;
  logic [DEPTH-1:0]        merge_cand;
  logic                    merge_hit;
  logic [PTR_W-1:0]        merge_idx;
  logic [DATA_W-1:0]       merge_data_unused;
  logic [PTR_W-1:0]        rd_idx_unused;
  logic                    in_flight;
  logic                    pop;
  logic                    alloc;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign addr_flat[g*ADDR_W +: ADDR_W] = addr_q[g];
    assign data_flat[g*DATA_W +: DATA_W] = data_q[g];
  end

  // The head line is frozen while memory is consuming it, so it cannot absorb
  // a merge; a same-address eviction then allocates a fresh entry behind it.
  assign in_flight  = (state_q != EWB_IDLE);
  assign head_mask  = in_flight ? (DEPTH'(1) << head_q) : '0;
  assign merge_cand = valid_q & ~head_mask;

  ewb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_merge_match (
    .cand  (merge_cand),
    .addrs (addr_flat),
    .datas (data_flat),
    .head  (head_q),
    .key   (wr_addr),
    .hit   (merge_hit),
    .idx   (merge_idx),
    .data  (merge_data_unused)
  );

  ewb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_match (
    .cand  (valid_q),
    .addrs (addr_flat),
    .datas (data_flat),
    .head  (head_q),
    .key   (rd_addr),
    .hit   (rd_hit),
    .idx   (rd_idx_unused),
    .data  (rd_data)
  );

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_ack    = wr_req & (merge_hit | ~full);
  assign pop       = (state_q == EWB_WRITE) & mem_resp;
  assign alloc     = wr_ack & ~merge_hit;
  assign mem_addr  = addr_q[head_q];
  assign mem_wdata = data_q[head_q];

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (wr_ack) begin
      if (merge_hit) begin
        data_d[merge_idx] = wr_data;
      end else begin
        valid_d[tail_q] = 1'b1;
        addr_d[tail_q]  = wr_addr;
        data_d[tail_q]  = wr_data;
        tail_d          = tail_q + 1'b1;
      end
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  always_comb begin
    state_d   = state_q;
    mem_write = 1'b0;
    case (state_q)
      EWB_IDLE: begin
        if (count_q != '0) state_d = EWB_WRITE;
      end
      EWB_WRITE: begin
        mem_write = 1'b1;
        if (mem_resp) state_d = EWB_GAP;
      end
      EWB_GAP: begin
        state_d = (count_q != '0) ? EWB_WRITE : EWB_IDLE;
      end
      default: state_d = EWB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EWB_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_evict_write_buffer.sv
// Directed bench for evict_write_buffer: forwarding vector table plus
// hand-written multi-cycle sequences for drain, fill/wrap, coalesce and reset.
module tb_evict_write_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_req;
  logic [11:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_ack;
  logic         full;
  logic         empty;
  logic [11:0]  rd_addr;
  logic         rd_hit;
  logic [127:0] rd_data;
  logic         mem_write;
  logic [11:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  evict_write_buffer #(.DEPTH(4), .DATA_W(128), .ADDR_W(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .full      (full),
    .empty     (empty),
    .rd_addr   (rd_addr),
    .rd_hit    (rd_hit),
    .rd_data   (rd_data),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_resp  (mem_resp)
  );

  typedef struct {
    logic [11:0]  addr;
    logic         hit;
    logic [127:0] data;
  } fwd_vec_t;

  localparam logic [127:0] D_SE = 128'hDEAD0000_00000000_00000000_00000001;
  localparam logic [127:0] D1   = 128'h11111111_11111111_11111111_11111111;
  localparam logic [127:0] D2   = 128'h22222222_22222222_22222222_22222222;
  localparam logic [127:0] D3   = 128'h33333333_33333333_33333333_33333333;
  localparam logic [127:0] DA   = 128'hAAAA0000_0000AAAA_0000AAAA_0000AAAA;
  localparam logic [127:0] DB   = 128'hBBBB0000_0000BBBB_0000BBBB_0000BBBB;
  localparam logic [127:0] DX   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DY   = 128'h5A5A5A5A_A5A5A5A5_5A5A5A5A_A5A5A5A5;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs are driven at posedge+1 and outputs sampled at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] a, input logic [127:0] d, output int waits);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    waits   = 0;
    #1;
    while (!wr_ack && waits < 40) begin
      tick();
      #1;
      waits++;
    end
    if (waits >= 40) chk("push_timeout", 128'(waits), 128'(0));
    tick();
    wr_req = 1'b0;
  endtask

  task automatic serve(input string nm, input logic [11:0] a, input logic [127:0] d);
    int w = 0;
    #1;
    while (!mem_write && w < 40) begin
      tick();
      #1;
      w++;
    end
    chk({nm, "_mem_write"}, 128'(mem_write), 128'(1));
    chk({nm, "_addr"}, 128'(mem_addr), 128'(a));
    chk({nm, "_data"}, mem_wdata, d);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1;
    chk({nm, "_gap"}, 128'(mem_write), 128'(0));
  endtask

  fwd_vec_t fwd_tbl[5];

  initial begin
    int w;
    fwd_tbl[0] = '{12'h100, 1'b1, DX};
    fwd_tbl[1] = '{12'h101, 1'b0, 128'h0};
    fwd_tbl[2] = '{12'h200, 1'b1, DY};
    fwd_tbl[3] = '{12'h000, 1'b0, 128'h0};
    fwd_tbl[4] = '{12'h100, 1'b1, DX};

    rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; mem_resp = 1'b0;
    #3;
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_wr_ack", 128'(wr_ack), 128'(0));
    chk("rst_rd_hit", 128'(rd_hit), 128'(0));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single eviction: ack in cycle 0, mem_write in cycle 2, resp 3 cycles later.
    push(12'h0A3, D_SE, w);
    chk("se_ack_cycle0", 128'(w), 128'(0));
    #1;
    chk("se_cycle1_idle", 128'(mem_write), 128'(0));
    tick(); #1;
    chk("se_cycle2_write", 128'(mem_write), 128'(1));
    chk("se_cycle2_addr", 128'(mem_addr), 128'(12'h0A3));
    chk("se_cycle2_data", mem_wdata, D_SE);
    tick(); tick(); tick();
    chk("se_cycle5_hold", 128'(mem_write), 128'(1));
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1;
    chk("se_gap", 128'(mem_write), 128'(0));
    chk("se_empty", 128'(empty), 128'(1));
    tick(); #1;
    chk("se_idle", 128'(mem_write), 128'(0));

    // Fill and wrap.
    for (int i = 1; i <= 4; i++) begin
      push(12'(i), 128'(i) * 128'h1000_0001, w);
      chk("fw_push_ack", 128'(w), 128'(0));
    end
    #1;
    chk("fw_full", 128'(full), 128'(1));
    wr_req = 1'b1; wr_addr = 12'h005; wr_data = 128'h5 * 128'h1000_0001;
    #1;
    chk("fw_blocked0", 128'(wr_ack), 128'(0));
    chk("fw_head_addr", 128'(mem_addr), 128'(12'h001));
    tick(); #1;
    chk("fw_blocked1", 128'(wr_ack), 128'(0));
    mem_resp = 1'b1;
    #1;
    chk("fw_blocked_pop_cycle", 128'(wr_ack), 128'(0));
    tick();
    mem_resp = 1'b0;
    #1;
    chk("fw_ack_after_pop", 128'(wr_ack), 128'(1));
    tick();
    wr_req = 1'b0;
    #1;
    chk("fw_full_again", 128'(full), 128'(1));
    for (int i = 2; i <= 5; i++) serve("fw_drain", 12'(i), 128'(i) * 128'h1000_0001);
    #1;
    chk("fw_empty", 128'(empty), 128'(1));

    // Coalesce: the second 0x020 overwrites the buffered copy.
    push(12'h010, D1, w);
    tick(); #1;
    chk("co_writing", 128'(mem_write), 128'(1));
    push(12'h020, D2, w);
    push(12'h020, D3, w);
    chk("co_merge_ack", 128'(w), 128'(0));
    rd_addr = 12'h020;
    #1;
    chk("co_fwd_data", rd_data, D3);
    push(12'h030, D1, w);
    push(12'h040, D2, w);
    #1;
    chk("co_full_at_4", 128'(full), 128'(1));
    serve("co_0", 12'h010, D1);
    serve("co_1", 12'h020, D3);
    serve("co_2", 12'h030, D1);
    serve("co_3", 12'h040, D2);
    tick(); #1;
    chk("co_empty", 128'(empty), 128'(1));
    chk("co_idle", 128'(mem_write), 128'(0));

    // In-flight same address allocates behind the head.
    push(12'h040, DA, w);
    tick(); #1;
    chk("if_writing", 128'(mem_write), 128'(1));
    push(12'h040, DB, w);
    rd_addr = 12'h040;
    #1;
    chk("if_rd_hit", 128'(rd_hit), 128'(1));
    chk("if_rd_data", rd_data, DB);
    chk("if_head_frozen", mem_wdata, DA);
    serve("if_0", 12'h040, DA);
    serve("if_1", 12'h040, DB);
    tick(); #1;
    chk("if_empty", 128'(empty), 128'(1));

    // Forwarding: same-cycle push invisible, then table of lookups.
    push(12'h100, DX, w);
    wr_req = 1'b1; wr_addr = 12'h200; wr_data = DY; rd_addr = 12'h200;
    #1;
    chk("fd_same_cycle_ack", 128'(wr_ack), 128'(1));
    chk("fd_same_cycle_miss", 128'(rd_hit), 128'(0));
    tick();
    wr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_addr = fwd_tbl[i].addr;
      #1;
      chk("fd_tbl_hit", 128'(rd_hit), 128'(fwd_tbl[i].hit));
      chk("fd_tbl_data", rd_data, fwd_tbl[i].data);
      tick();
    end
    serve("fd_0", 12'h100, DX);
    serve("fd_1", 12'h200, DY);
    rd_addr = 12'h100;
    tick(); #1;
    chk("fd_drained_miss", 128'(rd_hit), 128'(0));

    // Reset mid-write.
    push(12'h300, D1, w);
    push(12'h301, D2, w);
    push(12'h302, D3, w);
    #1;
    chk("rm_writing", 128'(mem_write), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rm_mem_write", 128'(mem_write), 128'(0));
    chk("rm_empty", 128'(empty), 128'(1));
    chk("rm_full", 128'(full), 128'(0));
    tick();
    rst_n = 1'b1;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1;
    chk("rm_resp_ignored_empty", 128'(empty), 128'(1));
    chk("rm_resp_ignored_write", 128'(mem_write), 128'(0));
    push(12'h3AA, DA, w);
    serve("rm_fresh", 12'h3AA, DA);
    tick(); tick(); #1;
    chk("rm_final_empty", 128'(empty), 128'(1));
    chk("rm_final_idle", 128'(mem_write), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
